multiword_add_sequencer: RTL and testbench
==========================================

Name: multiword_add_sequencer

Overview:
- Sequential front/back end for the combinational CarrySelectAdder_32_bit.
- Accepts multi-precision operands as a stream of 32-bit word pairs, least-significant word first, over a valid/ready handshake.
- Drives one instantiated CarrySelectAdder_32_bit per cycle and chains its cout into the next word's cin through a carry register.
- Returns registered 32-bit sum words on an output handshake, with the final carry on the last word.

Parameters:
- MAX_WORDS, 4: maximum words per operation; a longer packet is force-terminated.
- CNT_W, 3: word-counter width; must satisfy 2^CNT_W > MAX_WORDS.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  word pair present.
- in_ready  output  1  block can accept a word this cycle.
- in_a  input  32  operand A word.
- in_b  input  32  operand B word.
- in_cin  input  1  carry-in for the operation; sampled only with in_first.
- in_first  input  1  word is the least-significant word of a new operation.
- in_last  input  1  word is the most-significant word of the operation.
- out_valid  output  1  sum word held.
- out_ready  input  1  consumer accepts the sum word.
- out_sum  output  32  sum word.
- out_last  output  1  this is the final word of the operation.
- out_cout  output  1  final carry-out; meaningful only when out_last=1, else 0.
- err  output  1  one-cycle pulse on a protocol violation.

Behaviour:
- Reset: on a rst=1 sample, all of the following clear at the next edge: out_valid, out_sum, out_last, out_cout, err, carry register, word counter; state returns to IDLE. in_ready then evaluates to 1.
- Reset mid-operation discards any partial operation and any held output word without notification.
- Handshake and accept: in_ready = !out_valid || out_ready (single output register, combinational pass-through of ready). A word is accepted when in_valid && in_ready.
- Output transfer occurs when out_valid && out_ready. Accept and transfer may occur in the same cycle; the output register then reloads with no bubble.
- While in_ready=0, in_* are ignored and out_* hold stable.
- Latency: 1 cycle from accepted word to out_valid.
- Adder inputs: input1=in_a, input2=in_b, cin = in_first ? in_cin : carry_q. On accept, out_sum <= result and carry_q <= cout.
- State machine, IDLE to BUSY: accepting a word with in_first=1 and in_last=0.
- State machine, BUSY to IDLE: accepting a word with in_last=1.
- State machine, in_first=1 && in_last=1: single-word operation; state stays IDLE.
- State machine, in_first=0 while IDLE: the word is still accepted and processed as the first word with cin=in_cin. err pulses.
- State machine, in_first=1 while BUSY: the current operation is aborted and a new one starts using in_cin. err pulses. The previous packet is never marked last.
- Word counter: cleared on a first word, incremented on each accept. If an accepted word would be word number MAX_WORDS and in_last=0, the block treats it as last: out_last=1, state returns to IDLE, and err pulses.
- out_last and out_cout are registered with out_sum: out_last = effective last, out_cout = adder cout when last, else 0.
- err is registered; it is high for exactly one cycle following the offending accept.
- Arithmetic: modulo 2^(32*n) per operation. No saturation.

Optional Feature:
- Macro: MULTIWORD_OVF_DETECT_EN.
- When defined: adds output port out_ovf (1 bit), registered with out_sum, reset 0.
- On the last word it equals the signed overflow of the full-width operation: (a_msb == b_msb) && (sum_msb != a_msb) for the final word. On other words it is 0.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Single word: in_first=in_last=1, a=0x11ABCDEF, b=0x00AABBCC, cin=0 -> one cycle later out_sum=0x125689BB, out_last=1, out_cout=0, err=0.
- Two-word carry chain: (a,b) = (0xFFFFFFFF,0x00000001) then (0x00000000,0x00000000), out_ready=1 -> out_sum 0x00000000 (last=0), then 0x00000001 (last=1, cout=0). Back-to-back accepts with no bubble.
- Backpressure: hold out_ready=0 while streaming three words of 0x05233458+0x04578213 -> first sum 0x097AB66B held, in_ready=0 and output stable. Release out_ready -> words drain in order with none lost or duplicated.
- Length limit: MAX_WORDS=4, send 5 words with in_last=0 -> 4th output has out_last=1 and err pulses once. 5th word (first=0 in IDLE) starts a new operation and err pulses again.
- Abort and reset: assert in_first mid-packet -> err pulse and new carry taken from in_cin. Assert rst with out_valid=1 -> next cycle out_valid=0, out_sum=0, in_ready=1.
- With MULTIWORD_OVF_DETECT_EN: single word 0x7FFFFFFF+0x00000001 -> out_sum=0x80000000, out_ovf=1, out_cout=0.

Source files
------------

// File: rtl/multiword_add_sequencer.sv
// Multi-precision add sequencer around a 32-bit carry-select adder.
// Optional signed-overflow output: define MULTIWORD_OVF_DETECT_EN.

module CarrySelectAdder_32_bit (
    input  logic [31:0] input1,
    input  logic [31:0] input2,
    input  logic        cin,
    output logic [31:0] result,
    output logic        cout
);
    logic [4:0] c;

    assign c[0] = cin;
    assign cout = c[4];

    // Each byte precomputes both carry-in outcomes; the ripple only muxes.
    for (genvar g = 0; g < 4; g++) begin : g_blk
        logic [8:0] s0;
        logic [8:0] s1;
        assign s0 = {1'b0, input1[g*8 +: 8]} + {1'b0, input2[g*8 +: 8]};
        assign s1 = {1'b0, input1[g*8 +: 8]} + {1'b0, input2[g*8 +: 8]} + 9'd1;
        assign result[g*8 +: 8] = c[g] ? s1[7:0] : s0[7:0];
        assign c[g+1] = c[g] ? s1[8] : s0[8];
    end
endmodule

module multiword_add_sequencer #(
    parameter int MAX_WORDS = 4,
    parameter int CNT_W     = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    input  logic        in_cin,
    input  logic        in_first,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_sum,
    output logic        out_last,
    output logic        out_cout,
`ifdef MULTIWORD_OVF_DETECT_EN
    output logic        out_ovf,
`endif
    output logic        err
);
    typedef enum logic {IDLE, BUSY} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic               accept;
    logic               start;
    logic               force_last;
    logic               eff_last;
    logic               err_d;
    logic               add_cin;
    logic [CNT_W-1:0]   word_num;
    logic [31:0]        add_sum;
    logic               add_cout;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // A word in IDLE always opens an operation, flagged or not.
    assign start    = in_first || (state_q == IDLE);
    assign add_cin  = start ? in_cin : carry_q;
    assign word_num = start ? CNT_W'(1) : cnt_q + CNT_W'(1);

    assign force_last = (word_num == CNT_W'(MAX_WORDS)) && !in_last;
    assign eff_last   = in_last || force_last;

    CarrySelectAdder_32_bit u_add (
        .input1 (in_a),
        .input2 (in_b),
        .cin    (add_cin),
        .result (add_sum),
        .cout   (add_cout)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        err_d   = 1'b0;
        if (accept) begin
            carry_d = add_cout;
            cnt_d   = eff_last ? '0 : word_num;
            state_d = eff_last ? IDLE : BUSY;
            err_d   = (!in_first && state_q == IDLE)
                   || (in_first && state_q == BUSY)
                   || force_last;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            err     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            err     <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_last  <= 1'b0;
            out_cout  <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_sum   <= add_sum;
            out_last  <= eff_last;
            out_cout  <= eff_last && add_cout;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef MULTIWORD_OVF_DETECT_EN
    logic ovf_d;

    assign ovf_d = eff_last && (in_a[31] == in_b[31]) && (add_sum[31] != in_a[31]);

    always_ff @(posedge clk) begin
        if (rst) begin
            out_ovf <= 1'b0;
        end else if (accept) begin
            out_ovf <= ovf_d;
        end
    end
`endif
endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Scoreboard bench for multiword_add_sequencer: expected words are queued
// at accept time and compared as the consumer takes them.

module tb_multiword_add_sequencer;
    localparam int MAXW = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic        in_cin = 1'b0;
    logic        in_first = 1'b0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_sum;
    logic        out_last;
    logic        out_cout;
    logic        err;
`ifdef MULTIWORD_OVF_DETECT_EN
    logic        out_ovf;
`endif

    multiword_add_sequencer #(.MAX_WORDS(MAXW), .CNT_W(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .in_first  (in_first),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_last  (out_last),
        .out_cout  (out_cout),
`ifdef MULTIWORD_OVF_DETECT_EN
        .out_ovf   (out_ovf),
`endif
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] sum;
        logic        last;
        logic        cout;
        logic        ovf;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   popped = 0;
    int   pushed = 0;

    // Reference state of the operation in progress
    logic       m_busy = 1'b0;
    int         m_cnt = 0;
    logic       m_carry = 1'b0;

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            vectors++;
            if (q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_output sum=%h last=%b (queue empty)", out_sum, out_last);
            end else begin
                exp_t e;
                e = q.pop_front();
                popped++;
                if (out_sum !== e.sum || out_last !== e.last || out_cout !== e.cout) begin
                    miscompares++;
                    $display("FAIL out_word got sum=%h last=%b cout=%b want sum=%h last=%b cout=%b",
                             out_sum, out_last, out_cout, e.sum, e.last, e.cout);
                end
`ifdef MULTIWORD_OVF_DETECT_EN
                vectors++;
                if (out_ovf !== e.ovf) begin
                    miscompares++;
                    $display("FAIL out_ovf got %b want %b", out_ovf, e.ovf);
                end
`endif
            end
        end
    end

    task automatic send_word(input logic [31:0] a, input logic [31:0] b,
                             input logic cin, input logic first, input logic last,
                             output int waits);
        logic        st;
        logic        c;
        int          num;
        logic        frc;
        logic        eff;
        logic        experr;
        logic [32:0] s;
        exp_t        e;
        in_a = a;
        in_b = b;
        in_cin = cin;
        in_first = first;
        in_last = last;
        in_valid = 1'b1;
        waits = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            waits++;
            if (waits > 50) begin
                miscompares++;
                $display("FAIL accept_timeout in_ready stuck at %b, wanted 1", in_ready);
                in_valid = 1'b0;
                return;
            end
        end
        st = first || !m_busy;
        c = st ? cin : m_carry;
        num = st ? 1 : m_cnt + 1;
        frc = (num == MAXW) && !last;
        eff = last || frc;
        experr = (!first && !m_busy) || (first && m_busy) || frc;
        s = {1'b0, a} + {1'b0, b} + {32'd0, c};
        m_carry = s[32];
        m_busy = !eff;
        m_cnt = eff ? 0 : num;
        e.sum = s[31:0];
        e.last = eff;
        e.cout = eff && s[32];
        e.ovf = eff && (a[31] == b[31]) && (s[31] != a[31]);
        q.push_back(e);
        pushed++;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        vectors++;
        if (err !== experr) begin
            miscompares++;
            $display("FAIL err_pulse got %b want %b (a=%h first=%b last=%b)",
                     err, experr, a, first, last);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle(2);
        vectors++;
        if (out_valid !== 1'b0 || out_sum !== 32'h0 || in_ready !== 1'b1 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state got v=%b sum=%h rdy=%b err=%b want 0,0,1,0",
                     out_valid, out_sum, in_ready, err);
        end
        rst = 1'b0;
        idle(1);
    endtask

    task automatic test_single();
        int w;
        send_word(32'h11ABCDEF, 32'h00AABBCC, 1'b0, 1'b1, 1'b1, w);
        vectors++;
        if (out_valid !== 1'b1 || out_sum !== 32'h125689BB || out_last !== 1'b1 || out_cout !== 1'b0) begin
            miscompares++;
            $display("FAIL single_word got v=%b sum=%h last=%b cout=%b want 1,125689bb,1,0",
                     out_valid, out_sum, out_last, out_cout);
        end
        idle(2);
    endtask

    task automatic test_back_to_back();
        int w;
        send_word(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b1, 1'b0, w);
        send_word(32'h00000000, 32'h00000000, 1'b0, 1'b0, 1'b1, w);
        vectors++;
        if (w !== 0) begin
            miscompares++;
            $display("FAIL chain_bubble got %0d stall cycles want 0", w);
        end
        vectors++;
        if (out_sum !== 32'h00000001 || out_last !== 1'b1 || out_cout !== 1'b0) begin
            miscompares++;
            $display("FAIL chain_carry got sum=%h last=%b cout=%b want 00000001,1,0",
                     out_sum, out_last, out_cout);
        end
        idle(2);
    endtask

    task automatic test_backpressure();
        int w;
        out_ready = 1'b0;
        send_word(32'h05233458, 32'h04578213, 1'b0, 1'b1, 1'b0, w);
        fork
            send_word(32'h05233458, 32'h04578213, 1'b0, 1'b0, 1'b0, w);
            begin
                repeat (4) begin
                    @(negedge clk);
                    vectors++;
                    if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_sum !== 32'h097AB66B) begin
                        miscompares++;
                        $display("FAIL stall_hold got rdy=%b v=%b sum=%h want 0,1,097ab66b",
                                 in_ready, out_valid, out_sum);
                    end
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        vectors++;
        if (w < 4) begin
            miscompares++;
            $display("FAIL stall_wait got %0d stall cycles want >=4", w);
        end
        send_word(32'h05233458, 32'h04578213, 1'b0, 1'b0, 1'b1, w);
        idle(2);
    endtask

    task automatic test_length_limit();
        int w;
        for (int i = 0; i < 5; i++) begin
            send_word(32'h10000000 * i + 32'h1, 32'h2, 1'b0, i == 0, 1'b0, w);
            if (i == 3) begin
                vectors++;
                if (out_last !== 1'b1) begin
                    miscompares++;
                    $display("FAIL forced_last got %b want 1", out_last);
                end
            end
        end
        idle(1);
        vectors++;
        if (err !== 1'b0) begin
            miscompares++;
            $display("FAIL err_width got %b want 0", err);
        end
    endtask

    task automatic test_abort();
        int w;
        // Entered while still BUSY from the 5th word of the limit test
        send_word(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b1, 1'b0, w);
        send_word(32'h00000005, 32'h00000006, 1'b0, 1'b1, 1'b1, w);
        vectors++;
        if (out_sum !== 32'h0000000B || out_last !== 1'b1) begin
            miscompares++;
            $display("FAIL abort_cin got sum=%h last=%b want 0000000b,1", out_sum, out_last);
        end
        idle(2);
    endtask

    task automatic test_reset_midop();
        int w;
        out_ready = 1'b0;
        send_word(32'h12345678, 32'h11111111, 1'b0, 1'b1, 1'b0, w);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        q.delete();
        pushed = popped;
        m_busy = 1'b0;
        m_cnt = 0;
        m_carry = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || out_sum !== 32'h0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL midop_reset got v=%b sum=%h rdy=%b want 0,0,1",
                     out_valid, out_sum, in_ready);
        end
        out_ready = 1'b1;
        send_word(32'h00000003, 32'h00000004, 1'b1, 1'b1, 1'b1, w);
        vectors++;
        if (out_sum !== 32'h00000008) begin
            miscompares++;
            $display("FAIL post_reset_sum got %h want 00000008", out_sum);
        end
        idle(2);
    endtask

`ifdef MULTIWORD_OVF_DETECT_EN
    task automatic test_ovf();
        int w;
        send_word(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b1, 1'b1, w);
        vectors++;
        if (out_sum !== 32'h80000000 || out_ovf !== 1'b1 || out_cout !== 1'b0) begin
            miscompares++;
            $display("FAIL ovf_word got sum=%h ovf=%b cout=%b want 80000000,1,0",
                     out_sum, out_ovf, out_cout);
        end
        idle(2);
    endtask
`endif

    task automatic test_drain();
        int t;
        out_ready = 1'b1;
        t = 0;
        while (q.size() != 0 && t < 20) begin
            idle(1);
            t++;
        end
        vectors++;
        if (q.size() != 0 || pushed != popped) begin
            miscompares++;
            $display("FAIL drain got %0d left (pushed %0d popped %0d) want 0",
                     q.size(), pushed, popped);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_length_limit();
        test_abort();
        test_reset_midop();
`ifdef MULTIWORD_OVF_DETECT_EN
        test_ovf();
`endif
        test_drain();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
